// File: rtl/soc_matrix_irq_ctrl.sv
// soc_matrix_irq_ctrl: Avalon-MM interrupt aggregator with edge/level capture, masking,
// lowest-index priority reporting and count/timeout coalescing of the CPU irq.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   address[2:0]          s1 word address
//   chipselect, write_n   s1 select and active-low write strobe
//   writedata[15:0]       s1 write data
//   readdata[15:0]        s1 read data, registered (1 clk latency)
//   irq_in[NUM_IRQ-1:0]   source irq lines, synchronous to clk
//   irq                   aggregated interrupt to the CPU, registered
module soc_matrix_irq_ctrl #(
    parameter int NUM_IRQ = 8,
    parameter int TMO_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq
);
    typedef enum logic [1:0] {IDLE, ACCUM, FIRE} state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d, mask_q, mask_d, edge_sel_q, edge_sel_d;
    logic [NUM_IRQ-1:0] irq_in_dly_q, set, active;
    logic [7:0]         coal_cnt_q, coal_cnt_d, evt_cnt_q, evt_cnt_d;
    logic [TMO_W-1:0]   coal_tmo_q, coal_tmo_d, tmo_cnt_q, tmo_cnt_d;
    logic [15:0]        readdata_q, readdata_d;
    logic               irq_q, irq_d, wr, new_evt, valid, tmo_hit;
    logic [3:0]         id;

    assign wr       = chipselect & ~write_n;
    assign active   = pending_q & mask_q;
    assign valid    = |active;
    // Only sources that become newly pending count as coalescing events
    assign new_evt  = |(set & mask_q & ~pending_q);
    assign tmo_hit  = (coal_tmo_q != '0) && (tmo_cnt_q >= coal_tmo_q - TMO_W'(1));
    assign readdata = readdata_q;
    assign irq      = irq_q;

    // Register file; a capture in the same cycle as a W1C keeps the bit set
    always_comb begin
        set        = (edge_sel_q & irq_in & ~irq_in_dly_q) | (~edge_sel_q & irq_in);
        pending_d  = set | (pending_q & ~((wr && address == 3'd1) ? writedata[NUM_IRQ-1:0] : '0));
        mask_d     = (wr && address == 3'd2) ? writedata[NUM_IRQ-1:0] : mask_q;
        edge_sel_d = (wr && address == 3'd3) ? writedata[NUM_IRQ-1:0] : edge_sel_q;
        coal_cnt_d = (wr && address == 3'd5) ? writedata[7:0] : coal_cnt_q;
        coal_tmo_d = (wr && address == 3'd6) ? writedata[TMO_W-1:0] : coal_tmo_q;
    end

    // Lowest index wins: scan downward so the last hit is the smallest
    always_comb begin
        id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (active[i]) id = 4'(i);
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            3'd0:    readdata_d = 16'(irq_in);
            3'd1:    readdata_d = 16'(pending_q);
            3'd2:    readdata_d = 16'(mask_q);
            3'd3:    readdata_d = 16'(edge_sel_q);
            3'd4:    readdata_d = {valid, 11'b0, id};
            3'd5:    readdata_d = 16'(coal_cnt_q);
            3'd6:    readdata_d = 16'(coal_tmo_q);
            default: readdata_d = '0;
        endcase
    end

    // Coalescing FSM next state
    always_comb begin
        state_d   = state_q;
        evt_cnt_d = evt_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        case (state_q)
            IDLE:
                if (valid) begin
                    state_d   = (coal_cnt_q <= 8'd1) ? FIRE : ACCUM;
                    evt_cnt_d = 8'd1;
                    tmo_cnt_d = '0;
                end
            ACCUM:
                if (!valid) state_d = IDLE;
                else if (evt_cnt_q >= coal_cnt_q || tmo_hit) state_d = FIRE;
                else begin
                    tmo_cnt_d = (&tmo_cnt_q) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
                    evt_cnt_d = (new_evt && !(&evt_cnt_q)) ? evt_cnt_q + 8'd1 : evt_cnt_q;
                end
            FIRE:
                if (!valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output
    always_comb begin
        irq_d = (state_d == FIRE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            mask_q       <= '0;
            edge_sel_q   <= '0;
            irq_in_dly_q <= '0;
            coal_cnt_q   <= '0;
            coal_tmo_q   <= '0;
            evt_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            readdata_q   <= '0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            edge_sel_q   <= edge_sel_d;
            irq_in_dly_q <= irq_in;
            coal_cnt_q   <= coal_cnt_d;
            coal_tmo_q   <= coal_tmo_d;
            evt_cnt_q    <= evt_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            readdata_q   <= readdata_d;
            irq_q        <= irq_d;
        end
    end
endmodule
